// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: stall, squash, forwarding and a memory-wait watchdog.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WcW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StAbort   = 2'd2
  } state_e;

  state_e           state_q;
  logic [WcW-1:0]   wait_cnt_q;
  logic             mem_err_q;
  logic             load_use;
  logic             freeze;
  logic             abort_flush;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == src) return 2'b10;
    if (wb_reg_write && wb_rd != 5'd0 && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(ex_rs);
    fwd_b = fwd_sel(ex_rt);
  end

  always_comb begin
    load_use    = ex_mem_read && ex_rd != 5'd0 && (ex_rd == id_rs || ex_rd == id_rt);
    freeze      = 1'b0;
    abort_flush = 1'b0;
    case (state_q)
      StRun:     freeze = dmem_req && !dmem_ack;
      StMemWait: freeze = !dmem_ack;
      StAbort:   abort_flush = 1'b1;
      default:   ;
    endcase

    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    // Reset forces default controls even before the state register clears.
    if (rst) begin
      if (freeze) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        memwb_flush = 1'b1;
      end else begin
        memwb_flush = abort_flush;
        if (branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (dmem_req && !dmem_ack) begin
            state_q    <= StMemWait;
            wait_cnt_q <= WcW'(1);
          end
        end
        StMemWait: begin
          if (dmem_ack) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WcW'(MEM_TIMEOUT)) begin
            state_q    <= StAbort;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WcW'(1);
          end
        end
        StAbort: state_q <= StRun;
        default: state_q <= StRun;
      endcase
    end
  end

  assign state   = state_q;
  assign mem_err = mem_err_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] flush_count_q;

  // Both counters saturate at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!pc_write && stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (ifid_flush && flush_count_q != '1) flush_count_q <= flush_count_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected controls and counters are queued per step
// and compared against the DUT on the falling edge.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MemTimeout = 15;
  localparam int unsigned CntW       = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic            ex_mem_read, mem_reg_write, wb_reg_write, branch_taken, dmem_req, dmem_ack;
  logic            pc_write, ifid_write, idex_write, exmem_write;
  logic            ifid_flush, idex_flush, memwb_flush;
  logic [1:0]      fwd_a, fwd_b, state;
  logic            mem_err;
  logic [CntW-1:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MemTimeout), .CNT_W(CntW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_flush(memwb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  typedef struct {
    string           tag;
    logic [13:0]     ctl;
    logic [CntW-1:0] stall;
    logic [CntW-1:0] flush;
  } exp_t;

  exp_t            exp_q[$];
  int              checks   = 0;
  int              failures = 0;
  logic [CntW-1:0] m_stall  = '0;
  logic [CntW-1:0] m_flush  = '0;

  // {pc,ifid,idex,exmem writes, ifid,idex,memwb flushes, fwd_a, fwd_b, state, mem_err}
  function automatic logic [13:0] mk(input logic [3:0] wr, input logic [2:0] fl,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [1:0] st, input logic err);
    return {wr, fl, fa, fb, st, err};
  endfunction

  function automatic logic [13:0] obs_ctl();
    return {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, memwb_flush,
            fwd_a, fwd_b, state, mem_err};
  endfunction

  task automatic idle_inputs();
    {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
    {ex_mem_read, mem_reg_write, wb_reg_write, branch_taken, dmem_req, dmem_ack} = '0;
  endtask

  task automatic step(input string tag, input logic [13:0] ctl);
    exp_t e;
    exp_q.push_back('{tag, ctl, m_stall, m_flush});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    assert (obs_ctl() === e.ctl) else begin
      failures++;
      $error("FAIL %s ctl got %b want %b", e.tag, obs_ctl(), e.ctl);
    end
    checks++;
    assert (stall_cycles === e.stall) else begin
      failures++;
      $error("FAIL %s stall_cycles got %0d want %0d", e.tag, stall_cycles, e.stall);
    end
    checks++;
    assert (flush_count === e.flush) else begin
      failures++;
      $error("FAIL %s flush_count got %0d want %0d", e.tag, flush_count, e.flush);
    end
`ifdef HAZ_PERF_CNT_EN
    if (!rst) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (!ctl[13] && m_stall != '1) m_stall = m_stall + 1'b1;
      if (ctl[9] && m_flush != '1) m_flush = m_flush + 1'b1;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] WrAll  = 4'b1111;
  localparam logic [3:0] WrNone = 4'b0000;

  initial begin
    idle_inputs();
    rst = 1'b0;
    @(posedge clk);
    #1;
    step("reset", mk(WrAll, 3'b000, 2'b00, 2'b00, 2'd0, 1'b0));
    rst = 1'b1;

    ex_rs = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1;
    step("fwd_mem", mk(WrAll, 3'b000, 2'b10, 2'b00, 2'd0, 1'b0));
    mem_reg_write = 1'b0;
    step("fwd_wb", mk(WrAll, 3'b000, 2'b01, 2'b00, 2'd0, 1'b0));
    mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_write = 1'b1;
    step("fwd_r0", mk(WrAll, 3'b000, 2'b00, 2'b00, 2'd0, 1'b0));
    ex_rt = 5'd7; wb_rd = 5'd7;
    step("fwd_b_wb", mk(WrAll, 3'b000, 2'b00, 2'b01, 2'd0, 1'b0));
    idle_inputs();

    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rt = 5'd3;
    step("load_use", mk(4'b0011, 3'b010, 2'b00, 2'b00, 2'd0, 1'b0));
    ex_mem_read = 1'b0;
    step("load_use_clr", mk(WrAll, 3'b000, 2'b00, 2'b00, 2'd0, 1'b0));

    ex_mem_read = 1'b1; branch_taken = 1'b1;
    step("br_and_lu", mk(WrAll, 3'b110, 2'b00, 2'b00, 2'd0, 1'b0));
    idle_inputs();
    step("after_br", mk(WrAll, 3'b000, 2'b00, 2'b00, 2'd0, 1'b0));

    dmem_req = 1'b1;
    step("miss", mk(WrNone, 3'b001, 2'b00, 2'b00, 2'd0, 1'b0));
    branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
    step("wait1", mk(WrNone, 3'b001, 2'b00, 2'b00, 2'd1, 1'b0));
    branch_taken = 1'b0;
    step("wait2", mk(WrNone, 3'b001, 2'b00, 2'b00, 2'd1, 1'b0));
    ex_mem_read = 1'b0;
    step("wait3", mk(WrNone, 3'b001, 2'b00, 2'b00, 2'd1, 1'b0));
    dmem_ack = 1'b1;
    step("ack", mk(WrAll, 3'b000, 2'b00, 2'b00, 2'd1, 1'b0));
    idle_inputs();
    step("ack_run", mk(WrAll, 3'b000, 2'b00, 2'b00, 2'd0, 1'b0));

    dmem_req = 1'b1;
    step("to_miss", mk(WrNone, 3'b001, 2'b00, 2'b00, 2'd0, 1'b0));
    for (int i = 1; i <= int'(MemTimeout); i++) begin
      step($sformatf("to_wait%0d", i), mk(WrNone, 3'b001, 2'b00, 2'b00, 2'd1, 1'b0));
    end
    step("abort", mk(WrAll, 3'b001, 2'b00, 2'b00, 2'd2, 1'b1));
    dmem_req = 1'b0;
    step("post_abort", mk(WrAll, 3'b000, 2'b00, 2'b00, 2'd0, 1'b1));

    dmem_req = 1'b1;
    step("rst_miss", mk(WrNone, 3'b001, 2'b00, 2'b00, 2'd0, 1'b1));
    step("rst_wait", mk(WrNone, 3'b001, 2'b00, 2'b00, 2'd1, 1'b1));
    rst = 1'b0;
    step("rst_mid", mk(WrAll, 3'b000, 2'b00, 2'b00, 2'd1, 1'b1));
    rst = 1'b1; dmem_req = 1'b0;
    step("rst_after", mk(WrAll, 3'b000, 2'b00, 2'b00, 2'd0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
